// File: rtl/cache_dm_ctrl.sv
// cache_dm_ctrl: direct-mapped write-through cache controller.
// Define CACHE_STATS_EN to add saturating hit/miss counters.
module cache_dm_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES = 128,
  parameter int WRITE_ALLOCATE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wr,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MEM_RD,
    S_WAIT_RD,
    S_MEM_WR,
    S_FLUSH
  } state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic              hit_q;
  logic [IDX_W-1:0]  cnt_q;
  logic [LINES-1:0]  valid_q;

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic              accept;
  logic              line_we;
  logic [DATA_W-1:0] line_wdata;

  assign idx = addr_q[IDX_W-1:0];
  assign tag = addr_q[ADDR_W-1:IDX_W];
  assign hit = valid_q[idx] && (tag_mem[idx] == tag);

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    resp_rdata    = '0;
    resp_hit      = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_wr    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    accept        = 1'b0;
    line_we       = 1'b0;
    line_wdata    = '0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = rst_n && !flush;
        if (flush) begin
          state_d = S_FLUSH;
        end else if (req_valid && req_ready) begin
          accept  = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (wr_q) begin
          line_we    = hit || (WRITE_ALLOCATE != 0);
          line_wdata = wdata_q;
          state_d    = S_MEM_WR;
        end else if (hit) begin
          resp_valid = 1'b1;
          resp_hit   = 1'b1;
          resp_rdata = data_mem[idx];
          state_d    = S_IDLE;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = addr_q;
        if (mem_req_ready) state_d = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (mem_resp_valid) begin
          line_we    = 1'b1;
          line_wdata = mem_resp_rdata;
          resp_valid = 1'b1;
          resp_rdata = mem_resp_rdata;
          state_d    = S_IDLE;
        end
      end
      S_MEM_WR: begin
        mem_req_valid = 1'b1;
        mem_req_wr    = 1'b1;
        mem_req_addr  = addr_q;
        mem_req_wdata = wdata_q;
        // posted write: completion is the memory handshake itself
        if (mem_req_ready) begin
          resp_valid = 1'b1;
          resp_hit   = hit_q;
          state_d    = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (cnt_q == IDX_W'(LINES - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      hit_q   <= 1'b0;
      cnt_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wr_q    <= req_wr;
      end
      if (state_q == S_LOOKUP) hit_q <= hit;
      if (state_q == S_FLUSH) begin
        valid_q[cnt_q] <= 1'b0;
        cnt_q          <= cnt_q + IDX_W'(1);
      end
      if (line_we) valid_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= line_wdata;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state_q == S_IDLE && flush) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (resp_valid) begin
      if (resp_hit) begin
        if (stat_hits != '1) stat_hits <= stat_hits + 32'd1;
      end else begin
        if (stat_misses != '1) stat_misses <= stat_misses + 32'd1;
      end
    end
  end
`endif

endmodule
